// File: rtl/i2c_memory_slave.sv
// I2C responder holding a 128 x 8 register memory addressed by the 7-bit address field.
// One data byte per transaction; ACKs every address; open-drain sda drive (0 or z).
module i2c_memory_slave #(
  parameter int MEM_DEPTH   = 128,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  inout  wire  sda,
  output logic busy,
  output logic done,
  output logic ackErr
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    WR_DATA   = 3'd3,
    WR_ACK    = 3'd4,
    RD_DATA   = 3'd5,
    RD_ACK    = 3'd6,
    WAIT_STOP = 3'd7
  } state_t;

  state_t state_r, state_n;

  logic [SYNC_STAGES-1:0] scl_sync_r, sda_sync_r;
  logic       scl_prev_r, sda_prev_r;
  logic       scl_s, sda_s, scl_rise_s, scl_fall_s, start_s, stop_s;
  logic [3:0] bit_cnt_r, bit_cnt_n;
  logic [7:0] shift_r, shift_n;
  logic [7:0] tx_r, tx_n;
  logic [6:0] addr_r, addr_n;
  logic       rw_r, rw_n;
  logic       sda_oe_r, sda_oe_n;
  logic       busy_r, busy_n;
  logic       done_r, done_n;
  logic       ack_err_r, ack_err_n;
  logic       mem_we_s;
  logic [7:0] mem_r [MEM_DEPTH];

  assign sda    = sda_oe_r ? 1'b0 : 1'bz;
  assign busy   = busy_r;
  assign done   = done_r;
  assign ackErr = ack_err_r;

  // Input synchronisers and previous-value flops for edge / bus-condition detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync_r <= {SYNC_STAGES{1'b1}};
      sda_sync_r <= {SYNC_STAGES{1'b1}};
      scl_prev_r <= 1'b1;
      sda_prev_r <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl};
      sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda};
      scl_prev_r <= scl_s;
      sda_prev_r <= sda_s;
    end
  end

  assign scl_s      = scl_sync_r[SYNC_STAGES-1];
  assign sda_s      = sda_sync_r[SYNC_STAGES-1];
  assign scl_rise_s = scl_s & ~scl_prev_r;
  assign scl_fall_s = ~scl_s & scl_prev_r;
  // scl must be high on both samples so an sda edge racing an scl edge is not a bus condition
  assign start_s    = scl_s & scl_prev_r & sda_prev_r & ~sda_s;
  assign stop_s     = scl_s & scl_prev_r & ~sda_prev_r & sda_s;

  // Next-state, datapath and output decode
  always_comb begin
    state_n   = state_r;
    bit_cnt_n = bit_cnt_r;
    shift_n   = shift_r;
    tx_n      = tx_r;
    addr_n    = addr_r;
    rw_n      = rw_r;
    sda_oe_n  = sda_oe_r;
    busy_n    = busy_r;
    done_n    = 1'b0;
    ack_err_n = 1'b0;
    mem_we_s  = 1'b0;
    if (stop_s) begin
      state_n   = IDLE;
      busy_n    = 1'b0;
      sda_oe_n  = 1'b0;
      bit_cnt_n = 4'd0;
    end else if (start_s) begin
      state_n   = ADDR;
      busy_n    = 1'b1;
      sda_oe_n  = 1'b0;
      bit_cnt_n = 4'd0;
      shift_n   = 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          busy_n   = 1'b0;
          sda_oe_n = 1'b0;
        end
        ADDR: begin
          if (scl_rise_s && bit_cnt_r != 4'd8) begin
            shift_n   = {shift_r[6:0], sda_s};
            bit_cnt_n = bit_cnt_r + 4'd1;
          end else if (scl_fall_s && bit_cnt_r == 4'd8) begin
            state_n   = ADDR_ACK;
            addr_n    = shift_r[7:1];
            rw_n      = shift_r[0];
            tx_n      = mem_r[shift_r[7:1]];
            sda_oe_n  = 1'b1;
            bit_cnt_n = 4'd0;
          end else begin
            bit_cnt_n = bit_cnt_r;
          end
        end
        ADDR_ACK: begin
          if (scl_fall_s) begin
            bit_cnt_n = 4'd0;
            if (rw_r) begin
              state_n  = RD_DATA;
              sda_oe_n = ~tx_r[7];
              tx_n     = {tx_r[6:0], 1'b0};
            end else begin
              state_n  = WR_DATA;
              sda_oe_n = 1'b0;
              shift_n  = 8'd0;
            end
          end else begin
            sda_oe_n = 1'b1;
          end
        end
        WR_DATA: begin
          if (scl_rise_s && bit_cnt_r != 4'd8) begin
            shift_n   = {shift_r[6:0], sda_s};
            bit_cnt_n = bit_cnt_r + 4'd1;
          end else if (scl_fall_s && bit_cnt_r == 4'd8) begin
            state_n   = WR_ACK;
            sda_oe_n  = 1'b1;
            mem_we_s  = 1'b1;
            bit_cnt_n = 4'd0;
          end else begin
            bit_cnt_n = bit_cnt_r;
          end
        end
        WR_ACK: begin
          if (scl_fall_s) begin
            state_n  = WAIT_STOP;
            sda_oe_n = 1'b0;
            done_n   = 1'b1;
          end else begin
            sda_oe_n = 1'b1;
          end
        end
        // bit7 went out on entry; falls 1..7 present bits 6..0, fall 8 releases for the master bit
        RD_DATA: begin
          if (scl_fall_s) begin
            if (bit_cnt_r == 4'd7) begin
              state_n   = RD_ACK;
              sda_oe_n  = 1'b0;
              bit_cnt_n = 4'd0;
            end else begin
              sda_oe_n  = ~tx_r[7];
              tx_n      = {tx_r[6:0], 1'b0};
              bit_cnt_n = bit_cnt_r + 4'd1;
            end
          end else begin
            bit_cnt_n = bit_cnt_r;
          end
        end
        RD_ACK: begin
          sda_oe_n = 1'b0;
          if (scl_rise_s) begin
            state_n   = WAIT_STOP;
            done_n    = 1'b1;
            ack_err_n = ~sda_s;
          end else begin
            state_n = RD_ACK;
          end
        end
        WAIT_STOP: begin
          sda_oe_n = 1'b0;
        end
        default: begin
          state_n  = IDLE;
          busy_n   = 1'b0;
          sda_oe_n = 1'b0;
        end
      endcase
    end
  end

  // Control and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      bit_cnt_r <= 4'd0;
      shift_r   <= 8'd0;
      tx_r      <= 8'd0;
      addr_r    <= 7'd0;
      rw_r      <= 1'b0;
      sda_oe_r  <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      ack_err_r <= 1'b0;
    end else begin
      state_r   <= state_n;
      bit_cnt_r <= bit_cnt_n;
      shift_r   <= shift_n;
      tx_r      <= tx_n;
      addr_r    <= addr_n;
      rw_r      <= rw_n;
      sda_oe_r  <= sda_oe_n;
      busy_r    <= busy_n;
      done_r    <= done_n;
      ack_err_r <= ack_err_n;
    end
  end

  // Register memory; reset reloads the identity pattern mem[i] = i
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_r[i] <= i[7:0];
      end
    end else if (mem_we_s) begin
      mem_r[addr_r] <= shift_r;
    end else begin
      mem_r[addr_r] <= mem_r[addr_r];
    end
  end

endmodule

// File: tb/tb_i2c_memory_slave.sv
// Directed self-checking bench for i2c_memory_slave: a bit-banged I2C master drives
// write/read transactions and checks ACKs, read data, pulses and memory contents.
module tb_i2c_memory_slave;

  localparam int Q = 20;

  logic clk;
  logic rst;
  logic scl_m;
  logic m_sda_low;
  logic busy, done, ackErr;
  wire  sda;

  assign sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_memory_slave #(.MEM_DEPTH(128), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .scl(scl_m), .sda(sda),
    .busy(busy), .done(done), .ackErr(ackErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_hi = 0;
  int ackerr_hi = 0;
  int outside_hi = 0;
  int slave_low = 0;

  // pulse / drive monitors sampled on the inactive edge
  always @(negedge clk) begin
    if (done === 1'b1) done_hi <= done_hi + 1;
    if (ackErr === 1'b1) ackerr_hi <= ackerr_hi + 1;
    if ((done === 1'b1 || ackErr === 1'b1) && busy !== 1'b1) outside_hi <= outside_hi + 1;
    if (!m_sda_low && sda !== 1'b1) slave_low <= slave_low + 1;
  end

  task automatic wait_q();
    repeat (Q) @(posedge clk);
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; wait_q();
    scl_m = 1'b1;     wait_q();
    m_sda_low = 1'b1; wait_q();
    scl_m = 1'b0;     wait_q();
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; wait_q();
    scl_m = 1'b1;     wait_q();
    m_sda_low = 1'b0; wait_q();
    wait_q();
  endtask

  task automatic send_bit(input logic b);
    m_sda_low = ~b; wait_q();
    scl_m = 1'b1;   wait_q();
    wait_q();
    scl_m = 1'b0;   wait_q();
  endtask

  task automatic read_bit(output logic b);
    m_sda_low = 1'b0; wait_q();
    scl_m = 1'b1;     wait_q();
    @(negedge clk) b = sda;
    wait_q();
    scl_m = 1'b0;     wait_q();
  endtask

  task automatic send_byte(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
  endtask

  task automatic read_byte(output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
  endtask

  task automatic write_txn(input logic [6:0] a, input logic [7:0] d,
                           output logic ack_a, output logic ack_d);
    i2c_start();
    send_byte({a, 1'b0});
    read_bit(ack_a);
    send_byte(d);
    read_bit(ack_d);
    i2c_stop();
  endtask

  task automatic read_txn(input logic [6:0] a, input logic mack,
                          output logic [7:0] d, output logic ack_a);
    i2c_start();
    send_byte({a, 1'b1});
    read_bit(ack_a);
    read_byte(d);
    send_bit(~mack);
    i2c_stop();
  endtask

  task automatic test_reset();
    int s0, d0, e0;
    rst = 1'b0; scl_m = 1'b1; m_sda_low = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, ackErr} !== 3'b000) begin
      errors++; $display("FAIL reset_outputs: got %b expected 000", {busy, done, ackErr});
    end
    s0 = slave_low; d0 = done_hi; e0 = ackerr_hi;
    rst = 1'b1;
    repeat (2000) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL idle_busy: got %b expected 0", busy);
    end
    checks++;
    if ((slave_low - s0) != 0 || (done_hi - d0) != 0 || (ackerr_hi - e0) != 0) begin
      errors++;
      $display("FAIL idle_quiet: sda_low=%0d done=%0d ackErr=%0d expected all 0",
               slave_low - s0, done_hi - d0, ackerr_hi - e0);
    end
  endtask

  task automatic test_write();
    int d0;
    logic ack_a, ack_d;
    d0 = done_hi;
    i2c_start();
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL wr_busy_after_start: got %b expected 1", busy);
    end
    send_byte({7'h12, 1'b0});
    read_bit(ack_a);
    send_byte(8'hA5);
    read_bit(ack_d);
    i2c_stop();
    checks++;
    if ({ack_a, ack_d} !== 2'b00) begin
      errors++; $display("FAIL wr_acks: got %b expected 00", {ack_a, ack_d});
    end
    checks++;
    if ((done_hi - d0) != 1) begin
      errors++; $display("FAIL wr_done_cycles: got %0d expected 1", done_hi - d0);
    end
    checks++;
    if (dut.mem_r[7'h12] !== 8'hA5) begin
      errors++; $display("FAIL wr_mem12: got %h expected a5", dut.mem_r[7'h12]);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL wr_busy_after_stop: got %b expected 0", busy);
    end
  endtask

  task automatic test_read_nack();
    int d0, e0;
    logic [7:0] d;
    logic ack_a, a1, a2;
    d0 = done_hi; e0 = ackerr_hi;
    read_txn(7'h33, 1'b0, d, ack_a);
    checks++;
    if (d !== 8'h33 || ack_a !== 1'b0) begin
      errors++; $display("FAIL rd33_data: got %h ack=%b expected 33 ack=0", d, ack_a);
    end
    checks++;
    if ((done_hi - d0) != 1 || (ackerr_hi - e0) != 0) begin
      errors++; $display("FAIL rd33_pulses: done=%0d ackErr=%0d expected 1 0", done_hi - d0, ackerr_hi - e0);
    end
    write_txn(7'h33, 8'h5C, a1, a2);
    read_txn(7'h33, 1'b0, d, ack_a);
    checks++;
    if (d !== 8'h5C || {a1, a2, ack_a} !== 3'b000) begin
      errors++; $display("FAIL rd33_readback: got %h acks=%b expected 5c acks=000", d, {a1, a2, ack_a});
    end
  endtask

  task automatic test_read_ack();
    int d0, e0;
    logic [7:0] d;
    logic ack_a;
    d0 = done_hi; e0 = ackerr_hi;
    read_txn(7'h07, 1'b1, d, ack_a);
    checks++;
    if (d !== 8'h07) begin
      errors++; $display("FAIL rd07_data: got %h expected 07", d);
    end
    checks++;
    if ((done_hi - d0) != 1 || (ackerr_hi - e0) != 1) begin
      errors++; $display("FAIL rd07_pulses: done=%0d ackErr=%0d expected 1 1", done_hi - d0, ackerr_hi - e0);
    end
    checks++;
    if (dut.mem_r[7'h07] !== 8'h07) begin
      errors++; $display("FAIL rd07_mem: got %h expected 07", dut.mem_r[7'h07]);
    end
  endtask

  task automatic test_abort();
    int d0;
    logic [7:0] d;
    logic ack_a, b;
    d0 = done_hi;
    i2c_start();
    send_byte({7'h20, 1'b0});
    read_bit(b);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    i2c_stop();
    checks++;
    if (busy !== 1'b0 || dut.mem_r[7'h20] !== 8'h20 || (done_hi - d0) != 0) begin
      errors++;
      $display("FAIL abort_stop: busy=%b mem20=%h done=%0d expected 0 20 0",
               busy, dut.mem_r[7'h20], done_hi - d0);
    end
    // repeated START after four address bits must restart address capture
    d0 = done_hi;
    i2c_start();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    read_txn(7'h12, 1'b0, d, ack_a);
    checks++;
    if (d !== 8'hA5 || ack_a !== 1'b0 || (done_hi - d0) != 1) begin
      errors++;
      $display("FAIL rstart_read: got %h ack=%b done=%0d expected a5 0 1", d, ack_a, done_hi - d0);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] d;
    logic ack_a, a1, a2;
    i2c_start();
    send_byte({7'h00, 1'b1});
    read_bit(ack_a);
    @(negedge clk);
    checks++;
    if (sda !== 1'b0) begin
      errors++; $display("FAIL mid_read_drive: got %b expected 0", sda);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (sda !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_release: sda=%b busy=%b expected 1 0", sda, busy);
    end
    repeat (5) @(posedge clk);
    m_sda_low = 1'b0; scl_m = 1'b1;
    wait_q();
    rst = 1'b1;
    wait_q();
    checks++;
    if (dut.mem_r[7'h12] !== 8'h12) begin
      errors++; $display("FAIL reset_mem_reload: got %h expected 12", dut.mem_r[7'h12]);
    end
    write_txn(7'h55, 8'h3C, a1, a2);
    read_txn(7'h55, 1'b0, d, ack_a);
    checks++;
    if (d !== 8'h3C || {a1, a2, ack_a} !== 3'b000) begin
      errors++; $display("FAIL post_reset_txn: got %h acks=%b expected 3c 000", d, {a1, a2, ack_a});
    end
  endtask

  initial begin
    rst = 1'b0; scl_m = 1'b1; m_sda_low = 1'b0;
    test_reset();
    test_write();
    test_read_nack();
    test_read_ack();
    test_abort();
    test_reset_mid_read();
    checks++;
    if (outside_hi != 0) begin
      errors++; $display("FAIL pulse_outside_txn: got %0d expected 0", outside_hi);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
